regfile_ctrl: RTL and testbench
===============================

# regfile_ctrl

Scoreboard and write-port controller for the LC-3b register file. It tracks which architectural registers have an outstanding write, stalls decode on read-after-write and write-after-write hazards, and arbitrates the regfile's single write port between the ALU and memory writeback sources. It sits between decode/writeback and `regfile`, and drives the regfile's `load`/`dest`/`in` pins from registered outputs.

## Interface
Parameters:
- none; register count (8) and widths come from `lc3b_types` (`lc3b_reg` 3 bits, `lc3b_word` 16 bits)

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `iss_valid`  in  1  decode presents an instruction
- `iss_src_a`, `iss_src_b`  in  3 each  source registers
- `iss_use_a`, `iss_use_b`  in  1 each  source actually read
- `iss_wr`  in  1  instruction writes a register
- `iss_dest`  in  3  destination register
- `iss_ready`  out  1  issue accepted this cycle (combinational)
- `alu_valid`, `alu_dest`, `alu_data`  in  1/3/16  ALU writeback request
- `alu_ready`  out  1  ALU request granted (combinational)
- `mem_valid`, `mem_dest`, `mem_data`  in  1/3/16  memory writeback request
- `mem_ready`  out  1  MEM request granted (combinational)
- `rf_load`, `rf_dest`, `rf_in`  out  1/3/16  registered drive to regfile write port
- `busy`  out  8  per-register pending-write bits
- `err`  out  1  sticky: writeback to a non-busy register

## Operation
- Hazard: `haz = (iss_use_a & busy[iss_src_a]) | (iss_use_b & busy[iss_src_b]) | (iss_wr & busy[iss_dest])`.
- `iss_ready = iss_valid & ~haz`. On `iss_ready & iss_wr`, `busy[iss_dest]` sets at the next posedge.
- Current `busy` state only; no same-cycle bypass of retiring writes.
- Arbitration: among `alu_valid`/`mem_valid`, grant exactly one per cycle; `x_ready = x_valid & granted_x`. Requesters hold valid, dest and data stable until ready.
- On grant: at the next posedge, `rf_load<=1`, `rf_dest<=dest`, `rf_in<=data`, and `busy[dest]` clears. With no grant, `rf_load<=0`; `rf_dest`/`rf_in` hold.
- If the granted dest has `busy[dest]==0`, the write still occurs and `err` sets (sticky until reset).
- A set and a clear on the same register in the same cycle cannot occur: issue to a busy dest stalls. The RTL gives set priority regardless.
- One decode issue and one writeback may complete in the same cycle on different registers.

## Timing
- Reset (async assert, sync-safe deassert): `busy=0`, `rf_load=0`, `rf_dest=0`, `rf_in=0`, `err=0`, RR pointer favours MEM.
- `iss_ready`, `alu_ready`, `mem_ready`: combinational, 0 latency.
- Grant at cycle T: `rf_*` valid in T+1. `regfile` commits on the negedge inside T+1, and `busy` is clear from T+1. A dependent instruction can issue in T+1 and read the new value before the T+2 posedge.
- Reset mid-operation: all pending state is discarded; in-flight writeback requests are ignored until `rst_n` is high.

## Configuration
- `REGFILE_CTRL_RR_EN` defined: round-robin arbitration. When both request, grant the source not granted last; the pointer updates only on a contested grant. Reset state favours MEM.
- Undefined: fixed priority, MEM over ALU. The ALU may starve while MEM requests continuously.

## Structure
- `lc3b_types` gains `lc3b_wb_src` (enum ALU/MEM) and `LC3B_NUM_REGS = 8`; `busy` is typed from it.
- Sub-module `regfile_wb_arbiter`: 2-way arbiter (valids in, one-hot grant out, RR pointer under the macro).
- Scoreboard bits and `rf_*` output registers live in `regfile_ctrl`.

## Test plan
- Reset: assert `rst_n=0` mid-traffic -> all outputs 0 immediately; after release, `busy=8'h00`.
- RAW: issue wr R3 at T0; ALU writeback R3 with 16'h1234 granted at T3 -> `iss_ready=0` for a src_a=R3 instruction during T1–T3. In T4, `iss_ready=1`, `rf_load=1`, `rf_dest=3`, `rf_in=16'h1234`.
- WAW: issue wr R5 while `busy[5]=1` -> `iss_ready=0` until R5 retires; a non-using src (`iss_use_a=0`) on a busy reg does not stall.
- Contention: ALU and MEM both valid for 4 cycles (R1, R2 busy) -> with RR_EN, grants MEM, ALU, MEM, ALU. Without RR_EN, MEM on every cycle, and `alu_ready=0` until MEM drops.
- Concurrent: issue wr R6 while MEM retires R2 in the same cycle -> next cycle `busy[6]=1`, `busy[2]=0`, `rf_dest=2`.
- Error: ALU writeback R7 with `busy[7]=0` -> write occurs and `err=1`, still 1 after 10 idle cycles; cleared only by `rst_n`.

Source files
------------

// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b types for the register-file scoreboard slice.
// Contents: register index and data word types, busy-mask type sized by
// LC3B_NUM_REGS, the writeback source enum, the arbiter one-hot grant
// encodings and a one-hot helper function used for mask updates.
package lc3b_types;

  localparam int LC3B_NUM_REGS = 8;

  typedef logic [2:0]               lc3b_reg;
  typedef logic [15:0]              lc3b_word;
  typedef logic [LC3B_NUM_REGS-1:0] lc3b_reg_mask;

  typedef enum logic [0:0] {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } lc3b_wb_src;

  // One-hot grant encodings produced by the writeback arbiter.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_ALU  = 2'b01;
  localparam logic [1:0] GNT_MEM  = 2'b10;

  // Mask with only the bit of register r set.
  function automatic lc3b_reg_mask reg_onehot(input lc3b_reg r);
    lc3b_reg_mask m;
    m    = {LC3B_NUM_REGS{1'b0}};
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_ctrl_if.sv
// regfile_ctrl_if: bundle of decode-issue, writeback and regfile-drive
// signals around regfile_ctrl.
// Modports:
//   master - decode/writeback side: drives iss_*, alu_*, mem_* requests,
//            observes readies, rf_* drive, busy mask and err.
//   slave  - regfile_ctrl side: the mirror image.
interface regfile_ctrl_if;
  import lc3b_types::*;

  // decode issue
  logic         iss_valid;
  lc3b_reg      iss_src_a;
  lc3b_reg      iss_src_b;
  logic         iss_use_a;
  logic         iss_use_b;
  logic         iss_wr;
  lc3b_reg      iss_dest;
  logic         iss_ready;
  // ALU writeback
  logic         alu_valid;
  lc3b_reg      alu_dest;
  lc3b_word     alu_data;
  logic         alu_ready;
  // memory writeback
  logic         mem_valid;
  lc3b_reg      mem_dest;
  lc3b_word     mem_data;
  logic         mem_ready;
  // regfile write port drive and status
  logic         rf_load;
  lc3b_reg      rf_dest;
  lc3b_word     rf_in;
  lc3b_reg_mask busy;
  logic         err;

  modport master (
    output iss_valid, iss_src_a, iss_src_b, iss_use_a, iss_use_b, iss_wr, iss_dest,
    output alu_valid, alu_dest, alu_data,
    output mem_valid, mem_dest, mem_data,
    input  iss_ready, alu_ready, mem_ready,
    input  rf_load, rf_dest, rf_in, busy, err
  );

  modport slave (
    input  iss_valid, iss_src_a, iss_src_b, iss_use_a, iss_use_b, iss_wr, iss_dest,
    input  alu_valid, alu_dest, alu_data,
    input  mem_valid, mem_dest, mem_data,
    output iss_ready, alu_ready, mem_ready,
    output rf_load, rf_dest, rf_in, busy, err
  );

endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: 2-way arbiter for the single regfile write port.
// Ports: alu_req, mem_req (requests in), grant (one-hot out, GNT_ALU/GNT_MEM);
//        clk, rst_n only when REGFILE_CTRL_RR_EN is defined.
// REGFILE_CTRL_RR_EN defined: round-robin; on contention grant the source
// not granted last, pointer moves only on contested grants, reset favours MEM.
// Undefined: fixed priority, MEM over ALU.
module regfile_wb_arbiter
  import lc3b_types::*;
(
`ifdef REGFILE_CTRL_RR_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic       alu_req,
  input  logic       mem_req,
  output logic [1:0] grant
);

`ifdef REGFILE_CTRL_RR_EN
  // Source that won the most recent contested grant; ALU at reset so MEM wins first.
  lc3b_wb_src last;

  // Round-robin grant selection.
  always_comb begin
    grant = GNT_NONE;
    if (alu_req && mem_req) begin
      if (last == WB_MEM) begin
        grant = GNT_ALU;
      end else begin
        grant = GNT_MEM;
      end
    end else if (mem_req) begin
      grant = GNT_MEM;
    end else if (alu_req) begin
      grant = GNT_ALU;
    end else begin
      grant = GNT_NONE;
    end
  end

  // Pointer update, only when both sources competed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= WB_ALU;
    end else if (alu_req && mem_req) begin
      last <= (grant == GNT_MEM) ? WB_MEM : WB_ALU;
    end else begin
      last <= last;
    end
  end
`else
  // Fixed priority grant: MEM always beats ALU.
  always_comb begin
    grant = GNT_NONE;
    if (mem_req) begin
      grant = GNT_MEM;
    end else if (alu_req) begin
      grant = GNT_ALU;
    end else begin
      grant = GNT_NONE;
    end
  end
`endif

endmodule

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: LC-3b register scoreboard and regfile write-port controller.
// Ports: clk, rst_n (async active-low), bus (regfile_ctrl_if.slave):
//   iss_* decode issue with combinational iss_ready (RAW/WAW stall),
//   alu_*/mem_* writeback requests with combinational readies,
//   rf_load/rf_dest/rf_in registered regfile write drive,
//   busy pending-write mask, err sticky writeback-to-idle-register flag.
// Option: REGFILE_CTRL_RR_EN selects round-robin writeback arbitration
//   (fixed MEM-over-ALU priority otherwise).
module regfile_ctrl
  import lc3b_types::*;
(
  input  logic           clk,
  input  logic           rst_n,
  regfile_ctrl_if.slave  bus
);

  lc3b_reg_mask busy_q;
  lc3b_reg_mask busy_next;
  logic         err_q;
  logic         err_next;
  logic         rf_load_q;
  lc3b_reg      rf_dest_q;
  lc3b_word     rf_in_q;

  logic         haz;
  logic         iss_fire;
  logic         alu_req;
  logic         mem_req;
  logic [1:0]   grant;
  logic         wb_fire;
  lc3b_reg      wb_dest;
  lc3b_word     wb_data;

  // Requests are masked while reset is held so in-flight writebacks are ignored.
  assign alu_req = rst_n & bus.alu_valid;
  assign mem_req = rst_n & bus.mem_valid;

  regfile_wb_arbiter u_arb (
`ifdef REGFILE_CTRL_RR_EN
    .clk     (clk),
    .rst_n   (rst_n),
`endif
    .alu_req (alu_req),
    .mem_req (mem_req),
    .grant   (grant)
  );

  // Hazard check against current busy state only (no bypass of retiring writes).
  always_comb begin
    haz = (bus.iss_use_a & busy_q[bus.iss_src_a]) |
          (bus.iss_use_b & busy_q[bus.iss_src_b]) |
          (bus.iss_wr    & busy_q[bus.iss_dest]);
    iss_fire = rst_n & bus.iss_valid & ~haz;
  end

  // Writeback source mux driven by the one-hot grant.
  always_comb begin
    case (grant)
      GNT_MEM: begin
        wb_fire = 1'b1;
        wb_dest = bus.mem_dest;
        wb_data = bus.mem_data;
      end
      GNT_ALU: begin
        wb_fire = 1'b1;
        wb_dest = bus.alu_dest;
        wb_data = bus.alu_data;
      end
      default: begin
        wb_fire = 1'b0;
        wb_dest = 3'd0;
        wb_data = 16'h0000;
      end
    endcase
  end

  // Next scoreboard state: clear on writeback, then set on issue so set wins.
  always_comb begin
    busy_next = busy_q;
    if (wb_fire) begin
      busy_next = busy_next & ~reg_onehot(wb_dest);
    end else begin
      busy_next = busy_next;
    end
    if (iss_fire && bus.iss_wr) begin
      busy_next = busy_next | reg_onehot(bus.iss_dest);
    end else begin
      busy_next = busy_next;
    end
    err_next = err_q | (wb_fire & ~busy_q[wb_dest]);
  end

  // Scoreboard, sticky error and regfile write-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= {LC3B_NUM_REGS{1'b0}};
      err_q     <= 1'b0;
      rf_load_q <= 1'b0;
      rf_dest_q <= 3'd0;
      rf_in_q   <= 16'h0000;
    end else begin
      busy_q    <= busy_next;
      err_q     <= err_next;
      rf_load_q <= wb_fire;
      if (wb_fire) begin
        rf_dest_q <= wb_dest;
        rf_in_q   <= wb_data;
      end else begin
        rf_dest_q <= rf_dest_q;
        rf_in_q   <= rf_in_q;
      end
    end
  end

  assign bus.iss_ready = iss_fire;
  assign bus.alu_ready = (grant == GNT_ALU);
  assign bus.mem_ready = (grant == GNT_MEM);
  assign bus.rf_load   = rf_load_q;
  assign bus.rf_dest   = rf_dest_q;
  assign bus.rf_in     = rf_in_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: self-checking bench for regfile_ctrl. A behavioural model
// predicts readies, busy and err; granted writebacks are queued and checked
// against the registered rf_* drive on the following cycle.
module tb_regfile_ctrl;
  import lc3b_types::*;

  logic clk;
  logic rst_n;
  regfile_ctrl_if bus ();

  regfile_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // model state
  lc3b_reg_mask busy_m;
  logic         err_m;
  logic         fav_mem_m;
  logic [18:0]  exp_q[$];
  logic [18:0]  mon_e;

  // expected / observed readies of the last step
  logic ei, ea, em, oi, oa, om;

  task automatic model_reset();
    busy_m    = 8'h00;
    err_m     = 1'b0;
    fav_mem_m = 1'b1;
    exp_q.delete();
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0; bus.iss_src_a = 3'd0; bus.iss_src_b = 3'd0;
    bus.iss_use_a = 1'b0; bus.iss_use_b = 1'b0; bus.iss_wr = 1'b0; bus.iss_dest = 3'd0;
    bus.alu_valid = 1'b0; bus.alu_dest = 3'd0; bus.alu_data = 16'h0000;
    bus.mem_valid = 1'b0; bus.mem_dest = 3'd0; bus.mem_data = 16'h0000;
  endtask

  task automatic set_iss(input logic v, input lc3b_reg a, input logic ua,
                         input lc3b_reg b, input logic ub, input logic wr, input lc3b_reg d);
    bus.iss_valid = v; bus.iss_src_a = a; bus.iss_use_a = ua;
    bus.iss_src_b = b; bus.iss_use_b = ub; bus.iss_wr = wr; bus.iss_dest = d;
  endtask

  task automatic set_alu(input logic v, input lc3b_reg d, input lc3b_word x);
    bus.alu_valid = v; bus.alu_dest = d; bus.alu_data = x;
  endtask

  task automatic set_mem(input logic v, input lc3b_reg d, input lc3b_word x);
    bus.mem_valid = v; bus.mem_dest = d; bus.mem_data = x;
  endtask

  // One clock cycle with current inputs: predict, sample readies, advance model.
  task automatic step();
    logic        haz_m;
    logic [18:0] e;
    #1;
    haz_m = (bus.iss_use_a && busy_m[bus.iss_src_a]) ||
            (bus.iss_use_b && busy_m[bus.iss_src_b]) ||
            (bus.iss_wr    && busy_m[bus.iss_dest]);
    ei = bus.iss_valid && !haz_m;
    em = bus.mem_valid && (!bus.alu_valid || fav_mem_m);
    ea = bus.alu_valid && !em;
    oi = bus.iss_ready; oa = bus.alu_ready; om = bus.mem_ready;
    e  = em ? {bus.mem_dest, bus.mem_data} : {bus.alu_dest, bus.alu_data};
    @(posedge clk);
    if (em || ea) begin
      exp_q.push_back(e);
      if (!busy_m[e[18:16]]) err_m = 1'b1;
      busy_m[e[18:16]] = 1'b0;
    end
    if (ei && bus.iss_wr) busy_m[bus.iss_dest] = 1'b1;
`ifdef REGFILE_CTRL_RR_EN
    if (bus.alu_valid && bus.mem_valid) fav_mem_m = !em;
`endif
    #1;
  endtask

  // Scoreboard monitor: each granted writeback must appear on rf_* next cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rf_load === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wb_unexpected: got rf_dest=%0d rf_in=%h, required no write", bus.rf_dest, bus.rf_in);
        end else begin
          mon_e = exp_q.pop_front();
          if ({bus.rf_dest, bus.rf_in} !== mon_e) begin
            n_fail++;
            $display("FAIL wb_data: got dest=%0d in=%h, required dest=%0d in=%h",
                     bus.rf_dest, bus.rf_in, mon_e[18:16], mon_e[15:0]);
          end
        end
      end else if (exp_q.size() != 0) begin
        n_cmp++; n_fail++;
        mon_e = exp_q.pop_front();
        $display("FAIL wb_missing: got rf_load=%b, required write dest=%0d in=%h",
                 bus.rf_load, mon_e[18:16], mon_e[15:0]);
      end
    end
  end

  task automatic test_reset();
    n_cmp++;
    if (bus.busy !== 8'h00 || bus.rf_load !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL reset_init: got busy=%h load=%b err=%b, required 00/0/0", bus.busy, bus.rf_load, bus.err);
    end
    n_cmp++;
    if (bus.rf_dest !== 3'd0 || bus.rf_in !== 16'h0000) begin
      n_fail++; $display("FAIL reset_init_rf: got dest=%0d in=%h, required 0/0000", bus.rf_dest, bus.rf_in);
    end
    set_iss(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1); step();
    set_iss(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4); step();
    idle(); set_alu(1'b1, 3'd4, 16'hBEEF); step();
    n_cmp++;
    if (bus.busy !== busy_m || bus.rf_load !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got busy=%h load=%b, required %h/1", bus.busy, bus.rf_load, busy_m);
    end
    // traffic still presented while reset hits between edges
    set_iss(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2);
    set_alu(1'b1, 3'd1, 16'h5555);
    set_mem(1'b1, 3'd1, 16'h6666);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (bus.busy !== 8'h00 || bus.rf_load !== 1'b0 || bus.rf_dest !== 3'd0 ||
        bus.rf_in !== 16'h0000 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL reset_async: got busy=%h load=%b dest=%0d in=%h err=%b, required all 0",
                         bus.busy, bus.rf_load, bus.rf_dest, bus.rf_in, bus.err);
    end
    n_cmp++;
    if (bus.iss_ready !== 1'b0 || bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got iss=%b alu=%b mem=%b, required 0/0/0",
                         bus.iss_ready, bus.alu_ready, bus.mem_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.busy !== 8'h00 || bus.rf_load !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold: got busy=%h load=%b, required 00/0", bus.busy, bus.rf_load);
    end
    rst_n = 1'b1; idle();
    @(posedge clk); #1;
    n_cmp++;
    if (bus.busy !== 8'h00) begin
      n_fail++; $display("FAIL reset_release: got busy=%h, required 00", bus.busy);
    end
  endtask

  task automatic test_raw();
    idle(); set_iss(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3); step();
    n_cmp++;
    if (oi !== ei || oi !== 1'b1) begin n_fail++; $display("FAIL raw_issue: got %b, required 1", oi); end
    for (int t = 1; t <= 3; t++) begin
      set_iss(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0);
      if (t == 3) set_alu(1'b1, 3'd3, 16'h1234);
      step();
      n_cmp++;
      if (oi !== ei || oi !== 1'b0) begin n_fail++; $display("FAIL raw_stall T%0d: got %b, required 0", t, oi); end
    end
    n_cmp++;
    if (oa !== ea || oa !== 1'b1) begin n_fail++; $display("FAIL raw_alu_grant: got %b, required 1", oa); end
    set_alu(1'b0, 3'd0, 16'h0000);
    n_cmp++;
    if (bus.rf_load !== 1'b1 || bus.rf_dest !== 3'd3 || bus.rf_in !== 16'h1234) begin
      n_fail++; $display("FAIL raw_rf: got load=%b dest=%0d in=%h, required 1/3/1234", bus.rf_load, bus.rf_dest, bus.rf_in);
    end
    step();
    n_cmp++;
    if (oi !== ei || oi !== 1'b1) begin n_fail++; $display("FAIL raw_release: got %b, required 1", oi); end
    idle();
  endtask

  task automatic test_waw();
    set_iss(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5); step();
    for (int t = 0; t < 3; t++) begin
      set_iss(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5); step();
      n_cmp++;
      if (oi !== ei || oi !== 1'b0) begin n_fail++; $display("FAIL waw_stall: got %b, required 0", oi); end
    end
    set_iss(1'b1, 3'd5, 1'b0, 3'd5, 1'b0, 1'b0, 3'd0); step();
    n_cmp++;
    if (oi !== ei || oi !== 1'b1) begin n_fail++; $display("FAIL waw_unused_src: got %b, required 1", oi); end
    set_iss(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5);
    set_mem(1'b1, 3'd5, 16'h0A5A); step();
    n_cmp++;
    if (oi !== 1'b0 || om !== 1'b1 || om !== em) begin
      n_fail++; $display("FAIL waw_retire: got iss=%b mem=%b, required 0/1", oi, om);
    end
    set_mem(1'b0, 3'd0, 16'h0000); step();
    n_cmp++;
    if (oi !== ei || oi !== 1'b1) begin n_fail++; $display("FAIL waw_reissue: got %b, required 1", oi); end
    idle(); set_alu(1'b1, 3'd5, 16'h00FF); step();
    idle(); step();
    n_cmp++;
    if (bus.busy !== busy_m || bus.busy !== 8'h00) begin
      n_fail++; $display("FAIL waw_end_busy: got %h, required 00", bus.busy);
    end
  endtask

  task automatic test_contention();
    lc3b_reg mem_list [4];
    lc3b_reg alu_list [4];
    logic    seen [4];
    logic    want [4];
    int      mi, ai, budget;
    mem_list = '{3'd2, 3'd4, 3'd6, 3'd0};
    alu_list = '{3'd1, 3'd3, 3'd5, 3'd7};
`ifdef REGFILE_CTRL_RR_EN
    want = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    want = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    mi = 0; ai = 0;
    for (int r = 0; r < 8; r++) begin
      set_iss(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'(r)); step();
    end
    idle();
    n_cmp++;
    if (bus.busy !== 8'hFF) begin n_fail++; $display("FAIL cont_busy_all: got %h, required FF", bus.busy); end
    for (int c = 0; c < 4; c++) begin
      set_mem(1'b1, mem_list[mi], 16'h1000 + 16'(mi));
      set_alu(1'b1, alu_list[ai], 16'h2000 + 16'(ai));
      step();
      n_cmp++;
      if (oa !== ea || om !== em) begin
        n_fail++; $display("FAIL cont_ready c%0d: got alu=%b mem=%b, required %b/%b", c, oa, om, ea, em);
      end
      seen[c] = om;
      if (om) mi++;
      if (oa) ai++;
    end
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (seen[c] !== want[c]) begin
        n_fail++; $display("FAIL cont_order c%0d: got mem_granted=%b, required %b", c, seen[c], want[c]);
      end
    end
    set_mem(1'b0, 3'd0, 16'h0000);
    budget = 20;
    while ((mi < 4 || ai < 4) && budget > 0) begin
      if (mi < 4) set_mem(1'b1, mem_list[mi], 16'h1000 + 16'(mi)); else set_mem(1'b0, 3'd0, 16'h0000);
      if (ai < 4) set_alu(1'b1, alu_list[ai], 16'h2000 + 16'(ai)); else set_alu(1'b0, 3'd0, 16'h0000);
      step();
      n_cmp++;
      if (oa !== ea || om !== em) begin
        n_fail++; $display("FAIL cont_drain: got alu=%b mem=%b, required %b/%b", oa, om, ea, em);
      end
      if (om) mi++;
      if (oa) ai++;
      budget--;
    end
    if (budget == 0) begin
      n_cmp++; n_fail++; $display("FAIL cont_timeout: got mi=%0d ai=%0d, required 4/4", mi, ai);
    end
    idle(); step();
    n_cmp++;
    if (bus.busy !== 8'h00 || bus.err !== err_m) begin
      n_fail++; $display("FAIL cont_end: got busy=%h err=%b, required 00/%b", bus.busy, bus.err, err_m);
    end
  endtask

  task automatic test_concurrent();
    set_iss(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2); step();
    set_iss(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd6);
    set_mem(1'b1, 3'd2, 16'hC0DE); step();
    n_cmp++;
    if (oi !== 1'b1 || om !== 1'b1) begin n_fail++; $display("FAIL conc_ready: got iss=%b mem=%b, required 1/1", oi, om); end
    idle();
    n_cmp++;
    if (bus.busy[6] !== 1'b1 || bus.busy[2] !== 1'b0 || bus.rf_dest !== 3'd2 || bus.busy !== busy_m) begin
      n_fail++; $display("FAIL conc_state: got busy=%h rf_dest=%0d, required %h/2", bus.busy, bus.rf_dest, busy_m);
    end
    set_alu(1'b1, 3'd6, 16'h6006); step();
    idle(); step();
  endtask

  task automatic test_error();
    n_cmp++;
    if (bus.err !== 1'b0 || err_m !== 1'b0) begin n_fail++; $display("FAIL err_pre: got %b, required 0", bus.err); end
    set_alu(1'b1, 3'd7, 16'h7777); step();
    n_cmp++;
    if (oa !== 1'b1) begin n_fail++; $display("FAIL err_grant: got %b, required 1", oa); end
    idle();
    n_cmp++;
    if (bus.err !== 1'b1 || bus.rf_in !== 16'h7777) begin
      n_fail++; $display("FAIL err_set: got err=%b in=%h, required 1/7777", bus.err, bus.rf_in);
    end
    repeat (10) step();
    n_cmp++;
    if (bus.err !== err_m || bus.err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b, required 1", bus.err); end
    rst_n = 1'b0; model_reset(); #1;
    n_cmp++;
    if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b, required 0", bus.err); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_raw();
    test_waw();
    test_contention();
    test_concurrent();
    test_error();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
